// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce reporter: small FIFO of captured nonces streamed MSB byte first over UART 8N1.
// Optional build macro GOLDEN_NONCE_DEDUP_EN discards a nonce equal to the last one pushed.
module golden_nonce_uart_tx #(
    parameter int BAUD_DIV        = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        hash_clk,
    input  logic        reset_n,
    input  logic        gn_valid,
    input  logic [31:0] gn_nonce,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        overflow
);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [31:0] mem [DEPTH];
    logic [31:0] shreg, shreg_nxt;
    logic [15:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [7:0]  cur_byte;
    logic        fifo_empty, fifo_full, pop, push_req, push, drop, baud_done;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = (state == IDLE) && !fifo_empty;

`ifdef GOLDEN_NONCE_DEDUP_EN
    logic [31:0] last_pushed;
    logic        last_valid;

    assign push_req = gn_valid && !(last_valid && (gn_nonce == last_pushed));

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pushed <= 32'd0;
            last_valid  <= 1'b0;
        end else if (push) begin
            last_pushed <= gn_nonce;
            last_valid  <= 1'b1;
        end
    end
`else
    assign push_req = gn_valid;
`endif

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign cur_byte   = shreg[31:24];

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        uart_tx      = 1'b1;
        case (state)
            IDLE: begin
                baud_cnt_nxt = 16'd0;
                if (!fifo_empty) begin
                    shreg_nxt    = mem[rd_ptr[AW-1:0]];
                    byte_idx_nxt = 2'd0;
                    bit_idx_nxt  = 3'd0;
                    state_nxt    = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (baud_done) begin
                    baud_cnt_nxt = 16'd0;
                    bit_idx_nxt  = 3'd0;
                    state_nxt    = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                uart_tx = cur_byte[bit_idx];
                if (baud_done) begin
                    baud_cnt_nxt = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                uart_tx = 1'b1;
                if (baud_done) begin
                    baud_cnt_nxt = 16'd0;
                    if (byte_idx != 2'd3) begin
                        shreg_nxt    = {shreg[23:0], 8'd0};
                        byte_idx_nxt = byte_idx + 2'd1;
                        state_nxt    = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            shreg    <= 32'd0;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            tx_busy  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            shreg    <= shreg_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            tx_busy  <= (state_nxt != IDLE) || (wr_ptr_nxt != rd_ptr_nxt);
            overflow <= overflow | drop;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= gn_nonce;
        end
    end
endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: two instances (BAUD_DIV 4 and 2) share stimulus and are
// checked every cycle against a frame-position model, plus literal decode/timing checks.
module tb_golden_nonce_uart_tx;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        gn_valid = 1'b0;
    logic [31:0] gn_nonce = 32'd0;
    logic [1:0]  tx, busy, ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    golden_nonce_uart_tx #(.BAUD_DIV(4), .FIFO_DEPTH_LOG2(2)) dut0 (
        .hash_clk(clk), .reset_n(reset_n), .gn_valid(gn_valid), .gn_nonce(gn_nonce),
        .uart_tx(tx[0]), .tx_busy(busy[0]), .overflow(ovf[0]));

    golden_nonce_uart_tx #(.BAUD_DIV(2), .FIFO_DEPTH_LOG2(2)) dut1 (
        .hash_clk(clk), .reset_n(reset_n), .gn_valid(gn_valid), .gn_nonce(gn_nonce),
        .uart_tx(tx[1]), .tx_busy(busy[1]), .overflow(ovf[1]));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Reference: a queue of nonces and, while sending, the cycle position inside a 40*B frame.
    logic [31:0] mf [2][16];
    int          mcnt [2];
    bit          mact [2];
    int          mpos [2];
    logic [31:0] mcur [2];
    bit          movf [2];
    logic [31:0] mlast [2];
    bit          mlv [2];
    logic        etx [2];
    logic        ebusy [2];

    function automatic int baud_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic logic line_bit(input logic [31:0] n, input int p, input int b);
        int byte_i;
        int k;
        byte_i = p / (10 * b);
        k = (p % (10 * b)) / b;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return n[24 - 8 * byte_i + (k - 1)];
    endfunction

    initial begin
        bit pop;
        bit full_b;
        bit dup;
        int b;
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mact[i] = 0; mpos[i] = 0; movf[i] = 0; mlv[i] = 0;
            mcur[i] = 0; mlast[i] = 0; etx[i] = 1'b1; ebusy[i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    mcnt[i] = 0; mact[i] = 0; mpos[i] = 0; movf[i] = 0; mlv[i] = 0;
                    etx[i] = 1'b1; ebusy[i] = 1'b0;
                end else begin
                    b = baud_of(i);
                    full_b = (mcnt[i] == D);
                    pop = !mact[i] && (mcnt[i] > 0);
                    if (pop) begin
                        mcur[i] = mf[i][0];
                        for (int k = 0; k < 15; k++) mf[i][k] = mf[i][k+1];
                        mcnt[i] = mcnt[i] - 1;
                        mact[i] = 1'b1;
                        mpos[i] = 0;
                    end else if (mact[i]) begin
                        mpos[i] = mpos[i] + 1;
                        if (mpos[i] == 40 * b) mact[i] = 1'b0;
                    end
`ifdef GOLDEN_NONCE_DEDUP_EN
                    dup = mlv[i] && (gn_nonce == mlast[i]);
`else
                    dup = 1'b0;
`endif
                    if (gn_valid && !dup) begin
                        if (!full_b || pop) begin
                            mf[i][mcnt[i]] = gn_nonce;
                            mcnt[i] = mcnt[i] + 1;
                            mlast[i] = gn_nonce;
                            mlv[i] = 1'b1;
                        end else begin
                            movf[i] = 1'b1;
                        end
                    end
                    etx[i] = mact[i] ? line_bit(mcur[i], mpos[i], b) : 1'b1;
                    ebusy[i] = mact[i] || (mcnt[i] > 0);
                end
            end
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, idx, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("cyc_tx", i, {31'd0, tx[i]}, {31'd0, etx[i]});
                chk("cyc_busy", i, {31'd0, busy[i]}, {31'd0, ebusy[i]});
                chk("cyc_ovf", i, {31'd0, ovf[i]}, {31'd0, movf[i]});
            end
        end
    end

    // Caller sits just after a negedge; the strobe is sampled on the next posedge.
    task automatic strobe(input logic [31:0] n);
        gn_valid = 1'b1;
        gn_nonce = n;
        @(negedge clk);
        gn_valid = 1'b0;
    endtask

    task automatic rx(input int i, output logic [31:0] w, output bit ok);
        int b;
        int n;
        b = baud_of(i);
        ok = 1'b1;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (tx[i] !== 1'b0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) begin
                ok = 1'b0;
                return;
            end
            repeat (b / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (b) @(negedge clk);
                w[24 - 8 * j + k] = tx[i];
            end
            repeat (b) @(negedge clk);
            if (tx[i] !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic rx_chk(input int i, input logic [31:0] exp);
        logic [31:0] w;
        bit ok;
        rx(i, w, ok);
        chk("rx_ok", i, {31'd0, ok}, 32'd1);
        chk("rx_nonce", i, w, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 2'b00 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 0, {30'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        gn_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        logic [31:0] r;

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_tx", 0, {31'd0, tx[0]}, 32'd1);
        chk("rst_busy", 0, {31'd0, busy[0]}, 32'd0);
        chk("rst_ovf", 0, {31'd0, ovf[0]}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // DEADBEEF: latency, byte content, busy length
        c0 = cyc;
        strobe(32'hDEADBEEF);
        chk("lat_still_high", 0, {31'd0, tx[0]}, 32'd1);
        @(negedge clk);
        chk("lat_start_low", 0, {31'd0, tx[0]}, 32'd0);
        rx_chk(0, 32'hDEADBEEF);
        n = 0;
        while (busy[0] !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall", 0, cyc - (c0 + 2), 160);
        wait_idle();

        // Nonce 0 occupies the line; 1..4 fill the FIFO, 5 is dropped
        do_reset();
        fork
            begin
                strobe(32'd0);
                repeat (2) @(negedge clk);
                for (int k = 1; k <= 5; k++) strobe(k);
            end
            begin
                for (int k = 0; k <= 4; k++) rx_chk(1, k);
            end
        join
        chk("ovf_set", 0, {31'd0, ovf[0]}, 32'd1);
        chk("ovf_set", 1, {31'd0, ovf[1]}, 32'd1);
        chk("model_ovf", 0, {31'd0, movf[0]}, 32'd1);
        wait_idle();

        // Full FIFO, push lands on the IDLE pop cycle of instance 0
        do_reset();
        c0 = cyc;
        strobe(32'hA0000001);
        for (int k = 2; k <= 5; k++) strobe(32'hA0000000 + k);
        while (cyc != c0 + 162) @(negedge clk);
        strobe(32'hA0000006);
        chk("pop_push_ovf", 0, {31'd0, ovf[0]}, 32'd0);
        chk("model_pop_push", 0, {31'd0, movf[0]}, 32'd0);
        for (int k = 2; k <= 6; k++) rx_chk(0, 32'hA0000000 + k);
        wait_idle();

        // Reset in the middle of a data byte
        do_reset();
        c0 = cyc;
        strobe(32'h11223344);
        while (cyc != c0 + 95) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_tx", 0, {31'd0, tx[0]}, 32'd1);
        chk("async_tx", 1, {31'd0, tx[1]}, 32'd1);
        chk("async_busy", 0, {31'd0, busy[0]}, 32'd0);
        chk("async_ovf", 0, {31'd0, ovf[0]}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        strobe(32'hCAFEF00D);
        rx_chk(0, 32'hCAFEF00D);
        wait_idle();

        // Repeated nonce
        do_reset();
        fork
            begin
                strobe(32'h00001234);
                strobe(32'h00001234);
                strobe(32'h00001235);
            end
            begin
                rx_chk(1, 32'h00001234);
`ifndef GOLDEN_NONCE_DEDUP_EN
                rx_chk(1, 32'h00001234);
`endif
                rx_chk(1, 32'h00001235);
            end
        join
        wait_idle();
        chk("dedup_ovf", 1, {31'd0, ovf[1]}, 32'd0);

        // Random nonces with random gaps
        do_reset();
        for (int k = 0; k < 64; k++) begin
            r = $urandom;
            strobe(r);
            n = $urandom_range(0, 100);
            repeat (n) @(negedge clk);
        end
        wait_idle();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
